// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, divisor width and the baud divisor formula.
// Latency: n/a (package). Backpressure: n/a.
// Used by the baud generator, slave-control and register blocks so all agree on the divisor.
package spi_pkg;

    localparam int DIV_W = 12;

    typedef enum logic [1:0] {
        SPI_RUN  = 2'b00,
        SPI_WAIT = 2'b01,
        SPI_STOP = 2'b10
    } spi_mode_e;

    // SCK half-period in system clocks: (sppr+1) << (spr+1). Range 2..2048.
    function automatic logic [DIV_W-1:0] spi_divisor(input logic [2:0] sppr,
                                                     input logic [2:0] spr);
        logic [DIV_W-1:0] base;
        logic [3:0]       shamt;
        base  = {{(DIV_W-3){1'b0}}, sppr} + {{(DIV_W-1){1'b0}}, 1'b1};
        shamt = {1'b0, spr} + 4'd1;
        return base << shamt;
    endfunction

endpackage

// File: rtl/spi_baud_generator.sv
// SPI SCK generator: half-period counter, registered sclk and sample/drive strobes one cycle ahead of each toggle.
// Latency: first sclk toggle baudratedivisor cycles after enable; strobes lead their toggle by one cycle.
// Backpressure: none; runs while ss is low in run/wait mode, returns to idle the cycle after enable drops.
//
// Ports: P_clk/P_rst (async active-low) clock and reset; spi_mode/spiswai/ss gate the enable;
// cpol/cpha select idle level and edge roles; sppr/spr pick the rate; baudratedivisor is the
// combinational half-period; sclk, sample_strobe, drive_strobe are registered.
module spi_baud_generator #(
    parameter int DIV_W = 12
) (
    input  logic             P_clk,
    input  logic             P_rst,
    input  logic [1:0]       spi_mode,
    input  logic             spiswai,
    input  logic             cpol,
    input  logic             cpha,
    input  logic             ss,
    input  logic [2:0]       sppr,
    input  logic [2:0]       spr,
    output logic [DIV_W-1:0] baudratedivisor,
    output logic             sclk,
    output logic             sample_strobe,
    output logic             drive_strobe
);

    import spi_pkg::*;

    localparam logic [DIV_W-1:0] ONE = {{(DIV_W-1){1'b0}}, 1'b1};

    logic             en;
    logic [DIV_W-1:0] div_m1;
    logic             wrap;
    logic             cpol_eff;
    logic             cpha_eff;
    logic             next_is_sample;

    logic [DIV_W-1:0] count_q, count_d;
    logic             sclk_q, sclk_d;
    logic             sample_q, sample_d;
    logic             drive_q, drive_d;
    logic             en_q, en_d;
    logic             cpol_lat_q, cpol_lat_d;
    logic             cpha_lat_q, cpha_lat_d;

    always_comb begin
        baudratedivisor = DIV_W'(spi_divisor(sppr, spr));
    end

    always_comb begin
        en         = ((spi_mode == SPI_RUN) || (spi_mode == SPI_WAIT)) && !spiswai && !ss;
        en_d       = en;
        // cpol/cpha are captured on the first enabled cycle and frozen for the rest of the run.
        cpol_eff   = en_q ? cpol_lat_q : cpol;
        cpha_eff   = en_q ? cpha_lat_q : cpha;
        cpol_lat_d = cpol_eff;
        cpha_lat_d = cpha_eff;

        div_m1 = baudratedivisor - ONE;
        // >= rather than == so a divisor shrunk below the current count still wraps at once.
        wrap   = (count_q >= div_m1);

        // The upcoming toggle leaves sclk_q; it is rising when sclk_q is 0. Sample edges are
        // the rising ones when cpol==cpha and the falling ones otherwise.
        next_is_sample = ((!sclk_q) == (cpol_eff == cpha_eff));

        count_d  = count_q;
        sclk_d   = sclk_q;
        sample_d = 1'b0;
        drive_d  = 1'b0;

        if (!en) begin
            count_d = '0;
            sclk_d  = cpol;
        end else if (wrap) begin
            count_d = '0;
            sclk_d  = !sclk_q;
        end else begin
            count_d = count_q + ONE;
            // Flag the cycle whose count sits on the wrap value: the toggle follows it.
            if (count_d == div_m1) begin
                sample_d = next_is_sample;
                drive_d  = !next_is_sample;
            end
        end
    end

    always_ff @(posedge P_clk or negedge P_rst) begin
        if (!P_rst) begin
            count_q    <= '0;
            sclk_q     <= 1'b0;
            sample_q   <= 1'b0;
            drive_q    <= 1'b0;
            en_q       <= 1'b0;
            cpol_lat_q <= 1'b0;
            cpha_lat_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            sclk_q     <= sclk_d;
            sample_q   <= sample_d;
            drive_q    <= drive_d;
            en_q       <= en_d;
            cpol_lat_q <= cpol_lat_d;
            cpha_lat_q <= cpha_lat_d;
        end
    end

    assign sclk          = sclk_q;
    assign sample_strobe = sample_q;
    assign drive_strobe  = drive_q;

endmodule

// File: doc/spi_baud_generator.md
# spi_baud_generator

SPI serial-clock and bit-strobe generator for the APB SPI master core.
- Converts the SPPR/SPR prescaler fields into `baudratedivisor`, which feeds the slave-control block that frames the 8-bit transfer.
- Produces `sclk` and single-cycle strobes that tell the shift register when to sample MISO and when to drive MOSI.
- Runs only while the slave-control block holds `ss` low.

## Interface
Parameters:
- `DIV_W`, 12: width of the divisor and the half-period counter.

Ports:
- `P_clk`  in  1  system clock; the single clock.
- `P_rst`  in  1  reset, asynchronous, active-low.
- `spi_mode`  in  2  operating mode: 00 run, 01 wait, 10/11 stop.
- `spiswai`  in  1  stop the SPI clock while in wait mode.
- `cpol`  in  1  SCK idle level.
- `cpha`  in  1  clock phase.
- `ss`  in  1  slave select from slave control, active low.
- `sppr`  in  3  prescaler select.
- `spr`  in  3  rate select.
- `baudratedivisor`  out  12  SCK half-period in `P_clk` cycles.
- `sclk`  out  1  serial clock.
- `sample_strobe`  out  1  one-cycle pulse; next `sclk` toggle is a sample edge.
- `drive_strobe`  out  1  one-cycle pulse; next `sclk` toggle is a drive edge.

## Operation
- Divisor:
  - `baudratedivisor = (sppr+1) << (spr+1)`.
  - Range is 2 (0/0) to 2048 (7/7); it always fits in 12 bits.
  - This is the only combinational output.
- Enable:
  - `en = (spi_mode==00 | spi_mode==01) & ~spiswai & ~ss`.
  - This matches the slave-control enable gated by `ss`.
- Idle (`en`=0):
  - `count` is forced to 0.
  - `sclk` takes `cpol` on the next edge.
  - Both strobes are 0.
- Active (`en`=1):
  - 12-bit `count` increments each cycle.
  - When `count >= baudratedivisor-1`: `count` goes to 0 and `sclk` toggles.
  - The `>=` compare guarantees a wrap if the divisor shrinks mid-transfer. Software must not change `sppr`/`spr` while `ss`=0, but the block must never run away.
- Edge classification:
  - Sample edge is the rising edge when `cpol==cpha`, otherwise the falling edge.
  - A toggle from `sclk==cpol` is rising if `cpol`=0.
  - `sample_strobe` is high in the cycle before a toggle that produces the sample edge.
  - `drive_strobe` is high in the cycle before a toggle that produces the drive edge.
  - The two strobes are mutually exclusive.
- Transfer framing:
  - The slave-control block holds `ss` low for `16*baudratedivisor` cycles, i.e. 16 toggles.
  - `sclk` therefore ends at `cpol`.
  - cpha=0: the first toggle is a sample edge.
  - cpha=1: the first toggle is a drive edge, and the last toggle is a sample edge.
- Stop mid-transfer: if `spiswai` is set in wait mode or `ss` rises, the block returns to idle next cycle. There is no partial-edge completion.

## Timing
- Reset values: `sclk`=0, `count`=0, `sample_strobe`=0, `drive_strobe`=0. `baudratedivisor` follows its inputs.
- After reset release with `cpol`=1, `sclk` reaches 1 on the first `P_clk` edge.
- First toggle: after `ss` falls, the first `sclk` toggle occurs exactly `baudratedivisor` cycles after the first cycle in which `en`=1. Each subsequent toggle follows after another `baudratedivisor` cycles.
- Strobes:
  - Registered; a strobe set on edge N coincides with `count==divisor-1` and the toggle happens on edge N+1.
  - With divisor 2, strobes are high on every other cycle.
- `sclk` is registered, with no combinational path from any input.
- `cpol`/`cpha` changes take effect only in idle. While `en`=1 they are ignored for `sclk` level and edge classification, which are latched on the `en` rising cycle.

## Structure
- Shared package `spi_pkg`:
  - `spi_mode` encodings: `SPI_RUN`=00, `SPI_WAIT`=01, `SPI_STOP`=10.
  - `DIV_W`.
  - A function `spi_divisor(sppr, spr)` returning the 12-bit divisor, so that the slave-control and register blocks use the identical formula.
- No sub-module; the counter, toggle and strobe logic are a single block.

## Test plan
- `sppr`=0, `spr`=0, `cpol`=0, `cpha`=0, `ss` low 32 cycles:
  - `baudratedivisor`=2.
  - 16 toggles with a period of 4 cycles.
  - 8 `sample_strobe` pulses preceding the rising edges; `sclk` ends at 0.
- `sppr`=7, `spr`=7:
  - `baudratedivisor`=2048.
  - First toggle 2048 cycles after `en`.
  - `count` never exceeds 2047.
- `cpol`=1, `cpha`=1, divisor 4, with the first strobe checked:
  - Idle `sclk`=1.
  - First toggle is falling and is a `drive_strobe`; second toggle is rising and is a `sample_strobe`.
- Mid-transfer stop, mode 01: set `spiswai`=1 after 5 toggles. `sclk` returns to `cpol` next cycle, strobes are 0 and `count`=0.
- Divisor shrink: change `spr` from 3 to 0 while `count`=10. `count` wraps to 0 with a toggle on the next cycle.
- Reset mid-transfer: `P_rst` is pulsed low asynchronously between clock edges. `sclk`, `count` and both strobes go to 0 immediately, without waiting for a `P_clk` edge.
